mmio_hub: RTL
=============

MMIO_HUB -- requirements
Module: mmio_hub

Interface
Parameters:
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1100_0000, the bus address of the switch port; every other register address is an offset from it.
REQ-002 The block SHALL have parameter IN_W, default 16, the switch input width (1..32).
REQ-003 The block SHALL have parameter OUT_W, default 16, the width of each output register (1..32).
REQ-004 The block SHALL have parameter NUM_OUT, default 2, the output register count (1..8).
REQ-005 The block SHALL have parameter NUM_BTN, default 4, the debounced button count (1..32).
REQ-006 The block SHALL have parameter DEBOUNCE_CYC, default 50000, the stable cycles required to accept a button change (>=2).

Ports:
REQ-007 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-008 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port IOBUS_ADDR, input, 32 bits: bus address.
REQ-010 The block SHALL have port IOBUS_OUT, input, 32 bits: write data from the CPU.
REQ-011 The block SHALL have port IOBUS_WR, input, 1 bit: write strobe.
REQ-012 The block SHALL have port IOBUS_IN, output, 32 bits: read data to the CPU.
REQ-013 The block SHALL have port SWITCHES, input, IN_W bits: asynchronous switch inputs.
REQ-014 The block SHALL have port BTNS, input, NUM_BTN bits: asynchronous raw buttons.
REQ-015 The block SHALL have port OUT_REGS, output, NUM_OUT*OUT_W bits: register k occupies bits [k*OUT_W +: OUT_W].
REQ-016 The block SHALL have port INTR, output, 1 bit: level interrupt request.

Function
REQ-017 Address map SHALL be:
- BASE+0x00: switches (RO)
- BASE+0x04: button pending (R, write-1-to-clear)
- BASE+0x08: interrupt enable (RW, NUM_BTN bits)
- BASE+0x0C: debounced button levels (RO)
- BASE+0x20*(k+1): OUT_REGS[k] (RW), k<NUM_OUT
REQ-018 Decode SHALL be exact 32-bit match; any other address reads 32'h0 and ignores writes.
REQ-019 IOBUS_IN SHALL be combinational from IOBUS_ADDR (zero read latency); narrower fields zero-extended.
REQ-020 Switch value read SHALL be SWITCHES after a 2-flop synchronizer (2-cycle latency, no debounce).
REQ-021 A write with IOBUS_WR=1 SHALL update the addressed register at the next CLK edge; OUT_REGS[k] takes IOBUS_OUT[OUT_W-1:0]; OUT_REGS changes only on a write or RESET.
REQ-022 Each button SHALL pass a 2-flop synchronizer, then a debounce counter:
- counter clears whenever the synced input equals the debounced level;
- otherwise it increments;
- after DEBOUNCE_CYC consecutive differing cycles the debounced level flips and the counter clears.
REQ-023 A 0->1 transition of a debounced level SHALL set the matching pending bit in the same cycle the level flips.
REQ-024 Pending write-1-to-clear SHALL clear only the bits written as 1; on the same cycle as a new rising edge on that bit, set SHALL win.
REQ-025 INTR SHALL be registered: INTR = |(pending & enable) of the previous cycle (1-cycle latency after a pending/enable change).
REQ-026 Glitches shorter than DEBOUNCE_CYC cycles SHALL produce no level change and no pending bit.

Reset
REQ-027 On RESET=1 at a CLK edge, the following SHALL be cleared to 0: OUT_REGS, pending, enable, debounced levels, counters, synchronizers and INTR.
REQ-028 RESET SHALL take priority over any concurrent write or debounce event; a debounce in progress SHALL be abandoned.
REQ-029 Combinational reads SHALL reflect the reset values during and after reset.

Structure
REQ-030 Package mmio_pkg SHALL hold the register offset constants (SW_OFS, PEND_OFS, IEN_OFS, BTNLVL_OFS, OUT_STRIDE=32'h20).
REQ-031 The design SHALL use one sub-module, mmio_debounce (synchronizer, counter and level for one button, with a rise pulse output), instantiated NUM_BTN times via generate.

Verification
REQ-032 With defaults, write 32'hABCD_1234 to 0x1100_0020 -> OUT_REGS[15:0]=16'h1234 the next cycle, and a read of 0x1100_0020 returns 32'h0000_1234.
REQ-033 Set SWITCHES=16'h00F0 -> a read of 0x1100_0000 returns 32'h0000_00F0 two cycles later; a read of 0x1100_0010 returns 0.
REQ-034 With DEBOUNCE_CYC=4, apply a 3-cycle pulse on BTNS[1] -> pending stays 0; hold BTNS[1] high for 6 cycles -> pending=4'b0010.
REQ-035 Write enable=4'b0010 -> INTR=1 the following cycle; write 32'h2 to 0x1100_0004 -> pending=0 and INTR=0 one cycle later.
REQ-036 Issue the W1C on bit 1 in the same cycle as a new rising debounced edge on BTNS[1] -> pending bit 1 remains 1.
REQ-037 Assert RESET mid-debounce with OUT_REGS nonzero -> all outputs are 0 the next cycle, and the held button needs a full DEBOUNCE_CYC cycles again.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared register map for the MMIO hub.
// All addresses are offsets from the hub's BASE_ADDR.
package mmio_pkg;

  localparam logic [31:0] SW_OFS     = 32'h0000_0000;
  localparam logic [31:0] PEND_OFS   = 32'h0000_0004;
  localparam logic [31:0] IEN_OFS    = 32'h0000_0008;
  localparam logic [31:0] BTNLVL_OFS = 32'h0000_000C;
  localparam logic [31:0] OUT_STRIDE = 32'h0000_0020;

  // Output register k sits one stride above the previous one.
  // Register 0 starts at OUT_STRIDE, leaving 0x00-0x1F for the input block.
  function automatic logic [31:0] out_ofs(input int unsigned k);
    return OUT_STRIDE * (k + 1);
  endfunction

endpackage

// File: rtl/mmio_debounce.sv
// One button: 2-flop synchronizer followed by a run-length debounce counter.
// Emits a single-cycle rise pulse on the cycle the debounced level goes high.
module mmio_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter holds how many differing cycles have already been seen,
  // so the flip happens on the DEBOUNCE_CYC-th one.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    rise    = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        rise    = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: synchronized switches, debounced buttons with
// write-1-to-clear pending bits and a level interrupt, plus output registers.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0000,
  parameter int          IN_W         = 16,
  parameter int          OUT_W        = 16,
  parameter int          NUM_OUT      = 2,
  parameter int          NUM_BTN      = 4,
  parameter int          DEBOUNCE_CYC = 50000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [31:0]              IOBUS_ADDR,
  input  logic [31:0]              IOBUS_OUT,
  input  logic                     IOBUS_WR,
  output logic [31:0]              IOBUS_IN,
  input  logic [IN_W-1:0]          SWITCHES,
  input  logic [NUM_BTN-1:0]       BTNS,
  output logic [NUM_OUT*OUT_W-1:0] OUT_REGS,
  output logic                     INTR
);

  logic [IN_W-1:0]    sw_s1_q, sw_s1_d;
  logic [IN_W-1:0]    sw_s2_q, sw_s2_d;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] ien_q, ien_d;
  logic [NUM_BTN-1:0] btn_lvl;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] pend_clr;
  logic [NUM_OUT-1:0][OUT_W-1:0] out_q, out_d;
  logic intr_q, intr_d;
  logic unused_wdata;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    mmio_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clock (CLK),
      .reset (RESET),
      .btn_in(BTNS[i]),
      .level (btn_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  // A fresh rising edge is OR'd in after the clear, so set beats W1C.
  always_comb begin
    sw_s1_d  = SWITCHES;
    sw_s2_d  = sw_s1_q;
    ien_d    = ien_q;
    out_d    = out_q;
    pend_clr = '0;
    intr_d   = |(pend_q & ien_q);
    if (IOBUS_WR) begin
      if (IOBUS_ADDR == BASE_ADDR + PEND_OFS) begin
        pend_clr = IOBUS_OUT[NUM_BTN-1:0];
      end
      if (IOBUS_ADDR == BASE_ADDR + IEN_OFS) begin
        ien_d = IOBUS_OUT[NUM_BTN-1:0];
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (IOBUS_ADDR == BASE_ADDR + out_ofs(k)) begin
          out_d[k] = IOBUS_OUT[OUT_W-1:0];
        end
      end
    end
    pend_d = (pend_q & ~pend_clr) | btn_rise;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      pend_q  <= '0;
      ien_q   <= '0;
      out_q   <= '0;
      intr_q  <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      pend_q  <= pend_d;
      ien_q   <= ien_d;
      out_q   <= out_d;
      intr_q  <= intr_d;
    end
  end

  // Zero-latency read mux; unmapped addresses fall through to zero.
  always_comb begin
    IOBUS_IN = '0;
    if (IOBUS_ADDR == BASE_ADDR + SW_OFS) begin
      IOBUS_IN[IN_W-1:0] = sw_s2_q;
    end
    if (IOBUS_ADDR == BASE_ADDR + PEND_OFS) begin
      IOBUS_IN[NUM_BTN-1:0] = pend_q;
    end
    if (IOBUS_ADDR == BASE_ADDR + IEN_OFS) begin
      IOBUS_IN[NUM_BTN-1:0] = ien_q;
    end
    if (IOBUS_ADDR == BASE_ADDR + BTNLVL_OFS) begin
      IOBUS_IN[NUM_BTN-1:0] = btn_lvl;
    end
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (IOBUS_ADDR == BASE_ADDR + out_ofs(k)) begin
        IOBUS_IN[OUT_W-1:0] = out_q[k];
      end
    end
  end

  assign OUT_REGS     = out_q;
  assign INTR         = intr_q;
  assign unused_wdata = ^IOBUS_OUT;

endmodule
